// File: rtl/ssd_pkg.sv
// Shared decode table and sizing helpers for the seven-segment mux driver.
package ssd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Active-high gfedcba patterns, lower-case b and d so 8/B and 0/D stay distinct.
    function automatic logic [6:0] hex_to_ssd(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ssd_slot_timer.sv
// Slot/digit scan counters, frame strobe and the brightness on-window compare.
module ssd_slot_timer
    import ssd_pkg::*;
#(
    parameter int TICK_DIV    = 8,
    parameter int DIGITS      = 2,
    parameter int GUARD       = 1,
    parameter int BRIGHT_BITS = 2,
    parameter int PHASE_W     = width_of(TICK_DIV),
    parameter int IDX_W       = width_of(DIGITS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BRIGHT_BITS-1:0] brightness,
    output logic [IDX_W-1:0]       idx,
    output logic                   lit,
    output logic                   boundary,
    output logic                   frame
);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam int                 SPAN       = TICK_DIV - GUARD;

    logic [PHASE_W-1:0]     phase;
    logic [BRIGHT_BITS-1:0] bright_q;
    logic [BRIGHT_BITS-1:0] bright_eff;
    logic [31:0]            thr;
    logic                   slot_end;

    assign slot_end = (phase == PHASE_LAST);
    assign boundary = slot_end && (idx == IDX_LAST);

    // Phase 0 sees the live input so the new level already governs this slot.
    assign bright_eff = (phase == '0) ? brightness : bright_q;
    assign thr = 32'(GUARD) + (((32'(bright_eff) + 32'd1) * 32'(SPAN)) >> BRIGHT_BITS);
    assign lit = (32'(phase) >= 32'(GUARD)) && (32'(phase) < thr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= '0;
            idx      <= '0;
            bright_q <= '0;
            frame    <= 1'b0;
        end else begin
            frame <= boundary;
            if (phase == '0)
                bright_q <= brightness;
            if (slot_end) begin
                phase <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                phase <= phase + PHASE_W'(1);
            end
        end
    end

endmodule

// File: rtl/ssd_mux_driver.sv
// Time-multiplexed seven-segment driver with frame-synchronous value updates,
// leading-zero blanking, PWM brightness and an all-off guard between digits.
module ssd_mux_driver
    import ssd_pkg::*;
#(
    parameter int DIGITS         = 2,
    parameter int CLK_HZ         = 24000000,
    parameter int REFRESH_HZ     = 1000,
    parameter int GUARD          = 16,
    parameter int BRIGHT_BITS    = 4,
    parameter bit SEG_ACTIVE_LOW = 1,
    parameter bit DIG_ACTIVE_LOW = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*DIGITS-1:0]    value,
    input  logic [DIGITS-1:0]      dp,
    input  logic                   lz_en,
    input  logic [BRIGHT_BITS-1:0] brightness,
    input  logic                   load,
    output logic [6:0]             seg_o,
    output logic                   dp_o,
    output logic [DIGITS-1:0]      dig_o,
    output logic                   frame_o
);

    localparam int                TICK_DIV = CLK_HZ / (REFRESH_HZ * DIGITS);
    localparam int                IDX_W    = width_of(DIGITS);
    localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] DIG_OFF  = {DIGITS{DIG_ACTIVE_LOW}};

    if (TICK_DIV <= GUARD + 1) begin : g_bad_div
        $error("ssd_mux_driver: TICK_DIV must exceed GUARD+1");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("ssd_mux_driver: DIGITS must be 1..8");
    end

    logic [IDX_W-1:0] idx;
    logic             lit;
    logic             boundary;

    ssd_slot_timer #(
        .TICK_DIV    (TICK_DIV),
        .DIGITS      (DIGITS),
        .GUARD       (GUARD),
        .BRIGHT_BITS (BRIGHT_BITS),
        .IDX_W       (IDX_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .brightness (brightness),
        .idx        (idx),
        .lit        (lit),
        .boundary   (boundary),
        .frame      (frame_o)
    );

    logic [4*DIGITS-1:0] pend_value, act_value;
    logic [DIGITS-1:0]   pend_dp, act_dp;
    logic                pend_lz, act_lz;

    // Pending shadow absorbs loads; only the frame boundary moves data to the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_lz    <= 1'b0;
            act_value  <= '0;
            act_dp     <= '0;
            act_lz     <= 1'b0;
        end else begin
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp;
                pend_lz    <= lz_en;
            end
            if (boundary) begin
                act_value <= load ? value : pend_value;
                act_dp    <= load ? dp    : pend_dp;
                act_lz    <= load ? lz_en : pend_lz;
            end
        end
    end

    logic [DIGITS-1:0] lead_zero;
    logic              all_zero;

    always_comb begin
        lead_zero = '0;
        all_zero  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            all_zero     = all_zero && (act_value[4*k +: 4] == 4'h0);
            lead_zero[k] = all_zero;
        end
    end

    logic [3:0]        nib;
    logic              sup;
    logic              dp_sel;
    logic [DIGITS-1:0] dig_next;
    logic [6:0]        seg_pat;

    always_comb begin
        nib      = 4'h0;
        sup      = 1'b0;
        dp_sel   = 1'b0;
        dig_next = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                nib         = act_value[4*k +: 4];
                sup         = act_lz & lead_zero[k];
                dp_sel      = act_dp[k];
                dig_next[k] = lit;
            end
        end
    end

    assign seg_pat = sup ? SEG_BLANK : hex_to_ssd(nib);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o <= SEG_OFF;
            dp_o  <= SEG_ACTIVE_LOW;
            dig_o <= DIG_OFF;
        end else begin
            seg_o <= lit ? (seg_pat ^ SEG_OFF) : SEG_OFF;
            dp_o  <= lit ? (dp_sel ^ SEG_ACTIVE_LOW) : SEG_ACTIVE_LOW;
            dig_o <= dig_next ^ DIG_OFF;
        end
    end

endmodule

// File: tb/tb_ssd_mux_driver.sv
// Scoreboard bench: stimulus queues expected lit runs, a monitor measures each run.
module tb_ssd_mux_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] value;
    logic [1:0] dp;
    logic       lz_en;
    logic [1:0] brightness;
    logic       load;
    logic [6:0] seg_o;
    logic       dp_o;
    logic [1:0] dig_o;
    logic       frame_o;

    ssd_mux_driver #(
        .DIGITS      (2),
        .CLK_HZ      (1600),
        .REFRESH_HZ  (100),
        .GUARD       (1),
        .BRIGHT_BITS (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp         (dp),
        .lz_en      (lz_en),
        .brightness (brightness),
        .load       (load),
        .seg_o      (seg_o),
        .dp_o       (dp_o),
        .dig_o      (dig_o),
        .frame_o    (frame_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] dig;
        logic [6:0] seg;
        logic       dp;
        int         len;
    } run_t;

    run_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n = 0;
    bit   mon_en = 1'b0;
    bit   frm_en = 1'b0;
    int   last_frame = 0;
    int   frames = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run_to(input int t);
        while (n < t) step();
    endtask

    task automatic exp_frame(input logic [6:0] s0, input logic p0,
                             input logic [6:0] s1, input logic p1, input int len);
        run_t r;
        r.dig = 2'b01; r.seg = s0; r.dp = p0; r.len = len;
        exp_q.push_back(r);
        r.dig = 2'b10; r.seg = s1; r.dp = p1; r.len = len;
        exp_q.push_back(r);
    endtask

    task automatic do_load(input logic [7:0] v, input logic [1:0] d, input logic lz);
        value = v; dp = d; lz_en = lz; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic release_and_check();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        last_frame = 0;
        @(negedge clk) check("rel_dig_c0", 32'(dig_o), 0);
        step();
        @(negedge clk) check("rel_dig_c1", 32'(dig_o), 0);
        step();
        @(negedge clk) check("rel_dig_c2", 32'(dig_o), 32'h1);
    endtask

    // Run monitor: measures each lit run and checks guard/one-hot on every cycle.
    logic       run_on = 1'b0;
    bit         cur_en;
    bit         cur_stable;
    run_t       cur;
    logic [1:0] prev_dig = 2'b00;

    always @(negedge clk) begin
        if (!rst_n) begin
            run_on   = 1'b0;
            prev_dig = 2'b00;
        end else begin
            check("one_hot", 32'($countones(dig_o) <= 1), 1);
            if (dig_o == 2'b00) begin
                check("off_seg", 32'(seg_o), 32'h7F);
                check("off_dp", 32'(dp_o), 1);
                if (run_on) begin
                    run_on = 1'b0;
                    if (cur_en) begin
                        if (exp_q.size() == 0) begin
                            check("run_unexpected", 1, 0);
                        end else begin
                            run_t e;
                            e = exp_q.pop_front();
                            check("run_dig", 32'(cur.dig), 32'(e.dig));
                            check("run_seg", 32'(cur.seg), 32'(e.seg));
                            check("run_dp", 32'(cur.dp), 32'(e.dp));
                            check("run_len", cur.len, e.len);
                            check("run_stable", 32'(cur_stable), 1);
                        end
                    end
                end
            end else if (!run_on) begin
                check("guard_gap", 32'(prev_dig), 0);
                run_on     = 1'b1;
                cur_en     = mon_en;
                cur_stable = 1'b1;
                cur.dig    = dig_o;
                cur.seg    = seg_o;
                cur.dp     = dp_o;
                cur.len    = 1;
            end else begin
                check("same_digit", 32'(dig_o), 32'(cur.dig));
                if (seg_o !== cur.seg || dp_o !== cur.dp) cur_stable = 1'b0;
                cur.len++;
            end
            prev_dig = dig_o;
        end
    end

    always @(negedge clk) begin
        if (rst_n && frm_en && frame_o) begin
            check("frame_gap", n - last_frame, 16);
            last_frame = n;
            frames++;
        end
    end

    initial begin
        value = 8'h00; dp = 2'b00; lz_en = 1'b0; brightness = 2'd3; load = 1'b0;
        mon_en = 1'b1;
        exp_frame(7'h40, 1'b1, 7'h40, 1'b1, 7);

        repeat (3) @(posedge clk);
        #2;
        check("rst_seg", 32'(seg_o), 32'h7F);
        check("rst_dp", 32'(dp_o), 1);
        check("rst_dig", 32'(dig_o), 0);
        check("rst_frame", 32'(frame_o), 0);

        frm_en = 1'b1;
        release_and_check();

        exp_frame(7'h08, 1'b1, 7'h30, 1'b1, 7);
        do_load(8'h3A, 2'b00, 1'b0);

        run_to(28);
        exp_frame(7'h08, 1'b1, 7'h30, 1'b1, 1);
        brightness = 2'd0;
        run_to(44);
        exp_frame(7'h08, 1'b1, 7'h30, 1'b1, 5);
        brightness = 2'd2;

        run_to(51);
        do_load(8'h12, 2'b00, 1'b0);
        run_to(60);
        exp_frame(7'h24, 1'b1, 7'h79, 1'b1, 7);
        brightness = 2'd3;

        run_to(79);
        exp_frame(7'h12, 1'b1, 7'h19, 1'b1, 7);
        do_load(8'h45, 2'b00, 1'b0);

        run_to(85);
        exp_frame(7'h12, 1'b1, 7'h7F, 1'b0, 7);
        do_load(8'h05, 2'b10, 1'b1);
        run_to(101);
        exp_frame(7'h40, 1'b1, 7'h7F, 1'b1, 7);
        do_load(8'h00, 2'b00, 1'b1);

        run_to(129);
        mon_en = 1'b0;
        repeat (1600) begin
            if ($urandom_range(7) == 0) begin
                value = 8'($urandom); dp = 2'($urandom); lz_en = 1'($urandom);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(15) == 0) brightness = 2'($urandom);
            step();
        end
        load = 1'b0;

        while (n % 16 != 0) step();
        brightness = 2'd3;
        repeat (4) step();
        frm_en = 1'b0;
        check("frame_count", frames, (n - 1) / 16);
        check("queue_empty", exp_q.size(), 0);

        #2 rst_n = 1'b0;
        #1;
        check("midrst_seg", 32'(seg_o), 32'h7F);
        check("midrst_dp", 32'(dp_o), 1);
        check("midrst_dig", 32'(dig_o), 0);
        check("midrst_frame", 32'(frame_o), 0);
        repeat (2) @(posedge clk);
        release_and_check();
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_mux_driver.md
# ssd_mux_driver

Parametrised time-multiplexed seven-segment display driver for PMOD-attached LED displays on the iCEBreaker build. Scans `DIGITS` common-pin digits from a packed hex value. Adds per-digit decimal points, leading-zero suppression, PWM brightness, an anti-ghosting guard interval and tear-free frame-synchronous value updates. Sits between the design's status counters/registers and the P1A/P1B PMOD pins, clocked from the PLL core clock.

## Interface

- `DIGITS`, 2 — number of multiplexed digits (1..8).
- `CLK_HZ`, 24000000 — `clk` frequency.
- `REFRESH_HZ`, 1000 — full-frame scan rate.
- `GUARD`, 16 — all-off cycles at the start of each digit slot.
- `BRIGHT_BITS`, 4 — brightness control width.
- `SEG_ACTIVE_LOW`, 1 — polarity of `seg_o` and `dp_o`.
- `DIG_ACTIVE_LOW`, 0 — polarity of `dig_o`.
- Derived `TICK_DIV` = `CLK_HZ/(REFRESH_HZ*DIGITS)`. Elaboration error unless `TICK_DIV > GUARD+1`.

- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `value`  in  4*DIGITS  hex nibbles; nibble 0 (LSBs) is the rightmost digit.
- `dp`  in  DIGITS  decimal point per digit.
- `lz_en`  in  1  leading-zero suppression enable.
- `brightness`  in  BRIGHT_BITS  on-time level (0 dimmest, all-ones full).
- `load`  in  1  capture `value`/`dp`/`lz_en` into the pending shadow.
- `seg_o`  out  7  segments, bit0=a … bit6=g.
- `dp_o`  out  1  decimal point segment.
- `dig_o`  out  DIGITS  one-hot digit enable.
- `frame_o`  out  1  one-cycle pulse at each frame start.

## Operation

- Slot counter `phase` counts 0..TICK_DIV-1 and wraps. At wrap, digit index `idx` advances modulo DIGITS.
- Frame boundary = wrap with `idx` going DIGITS-1→0. At the boundary, `frame_o` pulses and active <= (`load` ? inputs : pending).
- `load` on any other cycle updates pending only. Display never changes mid-frame. Multiple loads in a frame: last one wins.
- `brightness` is sampled at phase 0 of every slot. Threshold `thr` = GUARD + (((brightness+1)*(TICK_DIV-GUARD)) >> BRIGHT_BITS).
- Digit `idx` is lit for GUARD ≤ phase < `thr`. All digits are inactive otherwise, including the guard interval.
- Decode: `hex_to_ssd(active_value[idx])`. The pattern is active-high gfedcba and is inverted when SEG_ACTIVE_LOW.
- Leading-zero suppression (`lz_en` active): digit k>0 shows blank segments if nibbles DIGITS-1..k are all zero. Digit 0 is never suppressed. `dp` is still honoured on suppressed digits.
- When no digit is lit, `seg_o`/`dp_o` are driven inactive.
- Reset values: `phase`=0, `idx`=0, active and pending cleared. `seg_o`/`dp_o` inactive (7'h7F/1 when active-low). `dig_o` all inactive, `frame_o`=0.
- Reset asserted mid-scan forces all of the above immediately. Scan restarts at digit 0, phase 0 after release.

## Timing

- All outputs are registered and lag `phase`/`idx` by 1 cycle.
- First digit lights GUARD+1 cycles after reset release.
- Digit-to-digit: at least GUARD fully-off cycles. `dig_o` is never multi-hot.
- `frame_o` asserts in the cycle after the boundary wrap, every DIGITS*TICK_DIV cycles.
- `load` to visible: the next frame boundary, plus 1 cycle. `load` on the boundary cycle itself is visible in that frame.
- `brightness` change takes effect at the next slot start.

## Structure

- `ssd_pkg` holds:
  - `hex_to_ssd` function (16-entry gfedcba table, e.g. 0→7'b0111111, F→7'b1110001);
  - `SEG_BLANK` constant;
  - a `clog2`-based width helper for `phase`/`idx`.
- Sub-module `ssd_slot_timer` holds `phase`/`idx`, wrap, `frame` strobe, `brightness` sampling and `thr`/lit compare. The top holds shadow/active registers, suppression logic, decode and output registers.

## Test plan

Bench parameters: CLK_HZ=1600, REFRESH_HZ=100, DIGITS=2, GUARD=1, BRIGHT_BITS=2, so TICK_DIV=8.

- Reset: hold `rst_n`=0 mid-scan → `seg_o`=7'h7F, `dp_o`=1, `dig_o`=2'b00, `frame_o`=0. Release → `dig_o`=2'b01 after 2 cycles; `frame_o` period is 16 cycles.
- Decode/scan: load `value`=8'h3A, brightness=3 → digit0 shows 7'b0001000 ('A', active-low) for 7 cycles. 1 off cycle, then digit1 shows 7'b0110000 ('3').
- Brightness: brightness=0 → each digit lit exactly 1 cycle per 8. Change to 2 mid-slot → 5 lit cycles starting next slot.
- Tear-free: `load` 8'h12 at phase 3 of digit0 → digit0 stays at the old value this frame. 8'h12 is shown from the next frame. `load` on the boundary cycle → shown immediately.
- Suppression: `value`=8'h05, `lz_en`=1, dp=2'b10 → digit1 segments blank with `dp_o` active; digit0 shows '5'. `value`=8'h00 → digit0 shows '0'.
- Guard/one-hot: run 100 frames with random loads → `dig_o` is never multi-hot, and every digit change is separated by ≥1 all-off cycle.
